// File: rtl/tx_pkg.sv
// Shared TX-path types and constants for the interpolating sample stage.
package tx_pkg;

    localparam int unsigned SAMPLE_W = 14;
    localparam int unsigned INTERP_R = 4;
    localparam int unsigned PH_W     = $clog2(INTERP_R);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } interp_state_t;

endpackage

// File: rtl/interp_lane.sv
// One channel of the x4 interpolator: sample history plus the per-phase output value.
module interp_lane
    import tx_pkg::*;
#(
    parameter int unsigned DW     = SAMPLE_W,
    parameter bit          LINEAR = 1'b1
) (
    input  logic                 clk_40mhz,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 load,
    input  logic                 hold,
    input  logic                 flush,
    input  logic [PH_W-1:0]      k,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] y_c
);

    localparam int unsigned SHIFT = $clog2(INTERP_R);

    logic signed [DW-1:0] x_prev;
    logic signed [DW-1:0] x_cur;
    logic signed [DW:0]   d;
    logic signed [DW+2:0] p;

    // Sample history: start primes both taps so the stream begins flat.
    always_ff @(posedge clk_40mhz or posedge rst) begin
        if (rst) begin
            x_prev <= '0;
            x_cur  <= '0;
        end else if (flush) begin
            x_prev <= '0;
            x_cur  <= '0;
        end else if (start) begin
            x_prev <= din;
            x_cur  <= din;
        end else if (load) begin
            x_prev <= x_cur;
            x_cur  <= din;
        end else if (hold) begin
            x_prev <= x_cur;
        end
    end

    // y = x_prev + floor(k*(x_cur-x_prev)/4); result stays between the taps so truncation is exact.
    always_comb begin
        d   = (DW+1)'(x_cur) - (DW+1)'(x_prev);
        p   = (DW+3)'($signed({1'b0, k})) * (DW+3)'(d);
        y_c = x_prev;
        if (LINEAR) begin
            y_c = x_prev + DW'(p >>> SHIFT);
        end
    end

endmodule

// File: rtl/interp4.sv
// x4 I/Q interpolator: 10 MS/s handshake input to a continuous 40 MS/s output stream.
module interp4
    import tx_pkg::*;
#(
    parameter int unsigned DW     = SAMPLE_W,
    parameter bit          LINEAR = 1'b1
) (
    input  logic                 clk_40mhz,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] data_in_I,
    input  logic signed [DW-1:0] data_in_Q,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] data_out_I,
    output logic signed [DW-1:0] data_out_Q,
    output logic                 out_valid,
    output logic                 underrun
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(INTERP_R - 1);

    interp_state_t        state;
    interp_state_t        state_nxt;
    logic [PH_W-1:0]      ph;
    logic [PH_W-1:0]      ph_nxt;
    logic                 accept_c;
    logic                 start_c;
    logic                 load_c;
    logic                 hold_c;
    logic                 flush_c;
    logic                 underrun_nxt;
    logic                 run_c;
    logic signed [DW-1:0] y_i;
    logic signed [DW-1:0] y_q;

    // Ready window: any time in IDLE, or on the last phase of a RUN period.
    assign in_ready = en && ((state == IDLE) || (ph == PH_LAST));
    assign accept_c = in_valid && in_ready;
    assign run_c    = (state == RUN) && en;

    // FSM state and phase register.
    always_ff @(posedge clk_40mhz or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ph       <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            ph       <= ph_nxt;
            underrun <= underrun_nxt;
        end
    end

    // Next state, phase and lane controls; a missing sample at the period end repeats x_cur.
    always_comb begin
        state_nxt    = state;
        ph_nxt       = ph;
        start_c      = 1'b0;
        load_c       = 1'b0;
        hold_c       = 1'b0;
        flush_c      = 1'b0;
        underrun_nxt = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            ph_nxt    = '0;
            flush_c   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ph_nxt = '0;
                    if (accept_c) begin
                        state_nxt = RUN;
                        start_c   = 1'b1;
                    end
                end
                RUN: begin
                    ph_nxt = ph + PH_W'(1);
                    if (ph == PH_LAST) begin
                        if (accept_c) begin
                            load_c = 1'b1;
                        end else begin
                            hold_c       = 1'b1;
                            underrun_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    ph_nxt    = '0;
                end
            endcase
        end
    end

    interp_lane #(.DW(DW), .LINEAR(LINEAR)) u_lane_i (
        .clk_40mhz (clk_40mhz),
        .rst       (rst),
        .start     (start_c),
        .load      (load_c),
        .hold      (hold_c),
        .flush     (flush_c),
        .k         (ph),
        .din       (data_in_I),
        .y_c       (y_i)
    );

    interp_lane #(.DW(DW), .LINEAR(LINEAR)) u_lane_q (
        .clk_40mhz (clk_40mhz),
        .rst       (rst),
        .start     (start_c),
        .load      (load_c),
        .hold      (hold_c),
        .flush     (flush_c),
        .k         (ph),
        .din       (data_in_Q),
        .y_c       (y_q)
    );

    // Output register: interpolated values while running, zeros otherwise.
    always_ff @(posedge clk_40mhz or posedge rst) begin
        if (rst) begin
            data_out_I <= '0;
            data_out_Q <= '0;
            out_valid  <= 1'b0;
        end else begin
            data_out_I <= run_c ? y_i : '0;
            data_out_Q <= run_c ? y_q : '0;
            out_valid  <= run_c;
        end
    end

endmodule
